sprite_bank_writer: RTL

//  Write side of the 32-entry sprite register bank read by the pixel comparator.

---
 rtl/sprite_bank_writer_pkg.sv | 36 +++
 rtl/sprite_bank_writer_if.sv | 12 +
 rtl/sprite_bank_writer_fifo.sv | 61 ++++++
 rtl/sprite_bank_writer.sv | 103 ++++++++++
 4 files changed

// File: rtl/sprite_bank_writer_pkg.sv
// Shared constants, state encoding and command packing for the sprite register bank.
// The pixel comparator imports the same field positions.
package sprite_bank_writer_pkg;

   localparam int SIZE_REG   = 32;
   localparam int N_REGS     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int ADDR_W     = $clog2(N_REGS);
   localparam int CMD_W      = ADDR_W + SIZE_REG;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

   localparam int SPR_X_HI = 28;
   localparam int SPR_X_LO = 19;
   localparam int SPR_Y_HI = 18;
   localparam int SPR_Y_LO = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [SIZE_REG-1:0] data;
   } cmd_t;

   function automatic cmd_t pack_cmd(input logic [ADDR_W-1:0] addr,
                                     input logic [SIZE_REG-1:0] data);
      cmd_t c;
      c.addr = addr;
      c.data = data;
      return c;
   endfunction

endpackage

// File: rtl/sprite_bank_writer_if.sv
// Valid/ready write-command channel from the instruction decoder into the sprite bank writer.
interface sprite_bank_writer_if;
   import sprite_bank_writer_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [SIZE_REG-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_addr, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_addr, input cmd_data, output cmd_ready);
endinterface

// File: rtl/sprite_bank_writer_fifo.sv
// Small synchronous FIFO holding pending write commands; pointers wrap modulo DEPTH.
module sync_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Guarding here keeps the FIFO consistent even if a caller ignores full/empty.
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == CNT_W'(0));
   assign count     = count_r;
   assign rd_data   = mem_r[rd_ptr_r];

   // Storage array, written at the tail.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/sprite_bank_writer.sv
// Queues CPU sprite-register writes and commits them to the 32-entry bank only during vblank,
// so the scan-out comparator never sees a half-updated sprite.
module sprite_bank_writer
   import sprite_bank_writer_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   sprite_bank_writer_if.slave          cmd,
   input  logic                         vblank,
   output logic [N_REGS*SIZE_REG-1:0]   regs_flat,
   output logic [CNT_W-1:0]             pending,
   output logic                         busy,
   output logic                         commit_pulse
);
   logic                               push_s;
   logic                               pop_s;
   logic                               full_s;
   logic                               empty_s;
   logic [CNT_W-1:0]                   count_s;
   logic [CNT_W-1:0]                   count_next_s;
   logic [CMD_W-1:0]                   head_raw_s;
   cmd_t                               head_s;
   state_t                             state_r;
   logic [N_REGS-1:0][SIZE_REG-1:0]    bank_r;
   logic                               commit_pulse_r;

   // Ready depends only on the registered occupancy, never on cmd_valid.
   assign cmd.cmd_ready = ~full_s;
   assign push_s        = cmd.cmd_valid & ~full_s;
   assign pop_s         = vblank & ~empty_s;
   assign head_s        = cmd_t'(head_raw_s);

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_s),
      .pop     (pop_s),
      .wr_data (CMD_W'(pack_cmd(cmd.cmd_addr, cmd.cmd_data))),
      .rd_data (head_raw_s),
      .full    (full_s),
      .empty   (empty_s),
      .count   (count_s)
   );

   // Occupancy after this edge, used to decide whether the FSM returns to IDLE.
   always_comb begin
      count_next_s = count_s;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_s + CNT_W'(1);
         2'b01:   count_next_s = count_s - CNT_W'(1);
         default: count_next_s = count_s;
      endcase
   end

   // Bank storage and commit strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_r         <= '0;
         commit_pulse_r <= 1'b0;
      end else begin
         commit_pulse_r <= pop_s;
         if (pop_s) begin
            bank_r[head_s.addr] <= head_s.data;
         end
      end
   end

   // Commit-window FSM: IDLE when empty, WAIT outside vblank, DRAIN while committing.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (push_s) begin
                  state_r <= vblank ? DRAIN : WAIT;
               end
            end
            WAIT: begin
               if (vblank) begin
                  state_r <= (count_next_s == CNT_W'(0)) ? IDLE : DRAIN;
               end
            end
            DRAIN: begin
               if (count_next_s == CNT_W'(0)) begin
                  state_r <= IDLE;
               end else if (!vblank) begin
                  state_r <= WAIT;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign regs_flat    = bank_r;
   assign pending      = count_s;
   assign busy         = (state_r != IDLE);
   assign commit_pulse = commit_pulse_r;
endmodule
